imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_stage.sv | 180 ++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// RISC-V immediate generator behind a 2-entry skid buffer (output register + skid register).
// Optional: define IMM_ILLEGAL_EN to add the out_illegal flag and its pipeline storage.
module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
`ifdef IMM_ILLEGAL_EN
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`else
    output logic [2:0]      out_fmt
`endif
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // Opcode table, entry 0 in the least significant slot.
    localparam int NOPC = 9;
    localparam logic [NOPC*7-1:0] OPC_TAB = {
        7'b1101111, 7'b0010111, 7'b0110111, 7'b1100011, 7'b0100011,
        7'b1100111, 7'b0011011, 7'b0010011, 7'b0000011
    };
    localparam logic [NOPC*3-1:0] FMT_TAB = {
        FMT_J, FMT_U, FMT_U, FMT_B, FMT_S,
        FMT_I, FMT_I, FMT_I, FMT_I
    };

    logic [2:0]      fmt_part [NOPC];
    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;

    genvar gi;
    generate
        for (gi = 0; gi < NOPC; gi++) begin : g_opc
            assign fmt_part[gi] = (in_instr[6:0] == OPC_TAB[gi*7 +: 7]) ? FMT_TAB[gi*3 +: 3] : FMT_NONE;
        end
    endgenerate

    always_comb begin
        dec_fmt = FMT_NONE;
        for (int i = 0; i < NOPC; i++) begin
            dec_fmt = dec_fmt | fmt_part[i];
        end
    end

    always_comb begin
        dec_imm32 = 32'd0;
        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
            FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_x64
            assign dec_imm = {{32{dec_imm32[31]}}, dec_imm32};
        end else begin : g_x32
            assign dec_imm = dec_imm32;
        end
    endgenerate

`ifdef IMM_ILLEGAL_EN
    logic dec_ill;
    assign dec_ill = (dec_fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);
    logic out_ill_reg, out_ill_next, skid_ill_reg, skid_ill_next;
`endif

    logic            in_ready_reg, in_ready_next;
    logic            out_valid_reg, out_valid_next;
    logic [XLEN-1:0] out_imm_reg, out_imm_next;
    logic [2:0]      out_fmt_reg, out_fmt_next;
    logic            skid_valid_reg, skid_valid_next;
    logic [XLEN-1:0] skid_imm_reg, skid_imm_next;
    logic [2:0]      skid_fmt_reg, skid_fmt_next;
    logic            in_fire;

    assign in_fire = in_valid && in_ready_reg;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_imm_next    = out_imm_reg;
        out_fmt_next    = out_fmt_reg;
        skid_valid_next = skid_valid_reg;
        skid_imm_next   = skid_imm_reg;
        skid_fmt_next   = skid_fmt_reg;
`ifdef IMM_ILLEGAL_EN
        out_ill_next    = out_ill_reg;
        skid_ill_next   = skid_ill_reg;
`endif
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!out_valid_reg || out_ready) begin
            // Output slot frees this edge: the older skid entry wins over new input.
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_imm_next    = skid_imm_reg;
                out_fmt_next    = skid_fmt_reg;
                skid_valid_next = 1'b0;
`ifdef IMM_ILLEGAL_EN
                out_ill_next    = skid_ill_reg;
`endif
            end else if (in_fire) begin
                out_valid_next = 1'b1;
                out_imm_next   = dec_imm;
                out_fmt_next   = dec_fmt;
`ifdef IMM_ILLEGAL_EN
                out_ill_next   = dec_ill;
`endif
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            skid_imm_next   = dec_imm;
            skid_fmt_next   = dec_fmt;
`ifdef IMM_ILLEGAL_EN
            skid_ill_next   = dec_ill;
`endif
        end
        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_imm_reg    <= '0;
            out_fmt_reg    <= FMT_NONE;
            skid_valid_reg <= 1'b0;
            skid_imm_reg   <= '0;
            skid_fmt_reg   <= FMT_NONE;
`ifdef IMM_ILLEGAL_EN
            out_ill_reg    <= 1'b0;
            skid_ill_reg   <= 1'b0;
`endif
        end else begin
            in_ready_reg   <= in_ready_next;
            out_valid_reg  <= out_valid_next;
            out_imm_reg    <= out_imm_next;
            out_fmt_reg    <= out_fmt_next;
            skid_valid_reg <= skid_valid_next;
            skid_imm_reg   <= skid_imm_next;
            skid_fmt_reg   <= skid_fmt_next;
`ifdef IMM_ILLEGAL_EN
            out_ill_reg    <= out_ill_next;
            skid_ill_reg   <= skid_ill_next;
`endif
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_imm   = out_imm_reg;
    assign out_fmt   = out_fmt_reg;
`ifdef IMM_ILLEGAL_EN
    assign out_illegal = out_ill_reg;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=64 and XLEN=32 instances share one input stream.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        in_ready32, out_valid32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
`ifdef IMM_ILLEGAL_EN
    logic        out_illegal, out_illegal32;
`endif

    int checks = 0;
    int errors = 0;

    imm_gen_stage #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
`ifdef IMM_ILLEGAL_EN
        .out_fmt(out_fmt), .out_illegal(out_illegal)
`else
        .out_fmt(out_fmt)
`endif
    );

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
`ifdef IMM_ILLEGAL_EN
        .out_fmt(out_fmt32), .out_illegal(out_illegal32)
`else
        .out_fmt(out_fmt32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0}; // sw -4
        vecs[2]  = '{32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0}; // beq -8
        vecs[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0}; // lui
        vecs[4]  = '{32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0}; // jal +2048
        vecs[5]  = '{32'h00000000, 64'h0000_0000_0000_0000, 3'd0, 1'b1}; // all zero
        vecs[6]  = '{32'h12345017, 64'h0000_0000_1234_5000, 3'd4, 1'b0}; // auipc
        vecs[7]  = '{32'h7FF12083, 64'h0000_0000_0000_07FF, 3'd1, 1'b0}; // lw +2047
        vecs[8]  = '{32'h8000009B, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0}; // addiw -2048
        vecs[9]  = '{32'h00008067, 64'h0000_0000_0000_0000, 3'd1, 1'b0}; // jalr
        vecs[10] = '{32'h002081B3, 64'h0000_0000_0000_0000, 3'd0, 1'b1}; // add (R-type)
        vecs[11] = '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0}; // jal -4
        vecs[12] = '{32'h00209463, 64'h0000_0000_0000_0008, 3'd3, 1'b0}; // bne +8
        vecs[13] = '{32'h7E000FA3, 64'h0000_0000_0000_07FF, 3'd2, 1'b0}; // sb +2047

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
        chk("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
`ifdef IMM_ILLEGAL_EN
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
`endif

        // Streaming vectors; first one lands on the first edge after reset release
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            @(negedge clk);
            $display("vec %0d instr %h -> imm %h fmt %0d", i, vecs[i].instr, out_imm, out_fmt);
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("vec%0d_fmt", i), {61'd0, out_fmt}, {61'd0, vecs[i].fmt});
            chk($sformatf("vec%0d_imm32", i), {32'd0, out_imm32}, {32'd0, vecs[i].imm[31:0]});
            chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
`ifdef IMM_ILLEGAL_EN
            chk($sformatf("vec%0d_ill", i), {63'd0, out_illegal}, {63'd0, vecs[i].ill});
            chk($sformatf("vec%0d_ill32", i), {63'd0, out_illegal32}, {63'd0, vecs[i].ill});
`endif
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Stall: three back-to-back words, only two accepted, order kept
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[0].instr;
        @(negedge clk);
        $display("stall A accepted, in_ready %0d", in_ready);
        chk("stall_a_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_a_imm", out_imm, vecs[0].imm);
        chk("stall_a_in_ready", {63'd0, in_ready}, 64'd1);
        in_instr = vecs[1].instr;
        @(negedge clk);
        $display("stall B into skid, in_ready %0d", in_ready);
        chk("stall_b_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_b_in_ready32", {63'd0, in_ready32}, 64'd0);
        chk("stall_b_hold_imm", out_imm, vecs[0].imm);
        in_instr = vecs[2].instr;
        repeat (2) @(negedge clk);
        $display("stall C refused, out_imm %h", out_imm);
        chk("stall_c_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_c_hold_imm", out_imm, vecs[0].imm);
        chk("stall_c_hold_fmt", {61'd0, out_fmt}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        $display("release: out_imm %h fmt %0d", out_imm, out_fmt);
        chk("rel_b_valid", {63'd0, out_valid}, 64'd1);
        chk("rel_b_imm", out_imm, vecs[1].imm);
        chk("rel_b_fmt", {61'd0, out_fmt}, 64'd2);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("rel_empty", {63'd0, out_valid}, 64'd0);

        // Flush with skid full and a concurrent input
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[3].instr;
        @(negedge clk);
        in_instr = vecs[4].instr;
        @(negedge clk);
        chk("fl_skid_full", {63'd0, in_ready}, 64'd0);
        in_instr = vecs[6].instr; flush = 1'b1;
        @(negedge clk);
        $display("flush: out_valid %0d in_ready %0d", out_valid, in_ready);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("fl_quiet%0d", k), {63'd0, out_valid}, 64'd0);
        end
        // Flush beats a handshake that would otherwise load the empty output
        in_valid = 1'b1; in_instr = vecs[7].instr; flush = 1'b1;
        @(negedge clk);
        chk("fl_empty_drop", {63'd0, out_valid}, 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_empty_quiet", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = vecs[8].instr;
        @(negedge clk);
        in_instr = vecs[9].instr;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("async reset: out_valid %0d in_ready %0d", out_valid, in_ready);
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        chk("ar_out_imm", out_imm, 64'd0);
        chk("ar_out_fmt", {61'd0, out_fmt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("ar_no_ghost", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b1; in_instr = 32'h00000000;
        @(negedge clk);
        $display("post reset zero word: imm %h fmt %0d", out_imm, out_fmt);
        chk("ar_zero_valid", {63'd0, out_valid}, 64'd1);
        chk("ar_zero_imm", out_imm, 64'd0);
`ifdef IMM_ILLEGAL_EN
        chk("ar_zero_ill", {63'd0, out_illegal}, 64'd1);
`endif
        in_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
